// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - sequencer state enum and decoded operation kinds
//   - instruction class, sub-op and branch condition codes
//   - default function-unit code for LDI and default reset PC
//   - cond_taken(): evaluates a branch condition against the flag register
package ctrl_pkg;

  localparam logic [3:0] FS_MOVB_DEFAULT  = 4'b1100;
  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [2:0] {
    OP_ALU, OP_LDI, OP_LD, OP_ST, OP_HALT, OP_BR, OP_JMP
  } op_e;

  // Instruction class, IR[15:14]
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MISC = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_JMP  = 2'b11;

  // Sub-op inside CLS_MISC, IR[13:12]
  localparam logic [1:0] SUB_LDI  = 2'b00;
  localparam logic [1:0] SUB_LD   = 2'b01;
  localparam logic [1:0] SUB_ST   = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  // Branch conditions, IR[13:11]
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_V      = 3'b101;

  // flags is packed {V, C, N, Z}; codes 110/111 are never taken.
  function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] flags);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[0];
      COND_NZ:     taken = ~flags[0];
      COND_N:      taken = flags[1];
      COND_C:      taken = flags[2];
      COND_V:      taken = flags[3];
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational instruction decoder.
//   ir       in  16  instruction register
//   op       out     decoded operation kind
//   da/aa/ba out 3   register selects (0 when unused by the class)
//   fs       out 4   function select (IR field for ALU, FS_MOVB for LDI)
//   mb       out 1   1 for LDI (operand B from const_in)
//   const_in out 8   immediate for LDI, 0 otherwise
//   cond     out 3   branch condition, IR[13:11]
//   imm8     out 8   IR[7:0]: branch offset or jump target
module instr_decode
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FS_MOVB = FS_MOVB_DEFAULT
) (
  input  logic [15:0] ir,
  output op_e         op,
  output logic [2:0]  da,
  output logic [2:0]  aa,
  output logic [2:0]  ba,
  output logic [3:0]  fs,
  output logic        mb,
  output logic [7:0]  const_in,
  output logic [2:0]  cond,
  output logic [7:0]  imm8
);

  always_comb begin
    op       = OP_ALU;
    da       = 3'd0;
    aa       = 3'd0;
    ba       = 3'd0;
    fs       = 4'd0;
    mb       = 1'b0;
    const_in = 8'd0;
    cond     = ir[13:11];
    imm8     = ir[7:0];
    case (ir[15:14])
      CLS_ALU: begin
        op = OP_ALU;
        fs = ir[13:10];
        da = ir[9:7];
        aa = ir[6:4];
        ba = ir[3:1];
      end
      CLS_MISC: begin
        case (ir[13:12])
          SUB_LDI: begin
            op       = OP_LDI;
            da       = ir[11:9];
            const_in = ir[7:0];
            fs       = FS_MOVB;
            mb       = 1'b1;
          end
          SUB_LD: begin
            op = OP_LD;
            da = ir[11:9];
            aa = ir[8:6];
          end
          SUB_ST: begin
            op = OP_ST;
            aa = ir[8:6];
            ba = ir[5:3];
          end
          default: op = OP_HALT;
        endcase
      end
      CLS_BR:  op = OP_BR;
      CLS_JMP: op = OP_JMP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/EXEC/MEM/HALT control unit driving the
// 8-bit datapath control word.
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/addr/data/valid instruction fetch port (addr = PC)
//   RW DA AA BA MB FS MD     datapath control word, const_in immediate
//   V C N Z                  datapath flags, latched after ALU-class EXEC
//   dmem_req/we/done         data-memory handshake for LD/ST
//   pc, halted               status
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FS_MOVB  = FS_MOVB_DEFAULT,
  parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        RW,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic        MB,
  output logic [3:0]  FS,
  output logic        MD,
  output logic [7:0]  const_in,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_done,
  output logic [7:0]  pc,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;  // {V, C, N, Z}

  op_e         dec_op;
  logic [2:0]  dec_da, dec_aa, dec_ba, dec_cond;
  logic [3:0]  dec_fs;
  logic        dec_mb;
  logic [7:0]  dec_const, dec_imm8;

  instr_decode #(.FS_MOVB(FS_MOVB)) u_decode (
    .ir       (ir_q),
    .op       (dec_op),
    .da       (dec_da),
    .aa       (dec_aa),
    .ba       (dec_ba),
    .fs       (dec_fs),
    .mb       (dec_mb),
    .const_in (dec_const),
    .cond     (dec_cond),
    .imm8     (dec_imm8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  // All outputs are decoded from state_q/ir_q, so an asynchronous reset
  // drops dmem_req and RW immediately.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    imem_req = 1'b0;
    RW       = 1'b0;
    DA       = 3'd0;
    AA       = 3'd0;
    BA       = 3'd0;
    MB       = 1'b0;
    FS       = 4'd0;
    MD       = 1'b0;
    const_in = 8'd0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        DA       = dec_da;
        AA       = dec_aa;
        BA       = dec_ba;
        FS       = dec_fs;
        MB       = dec_mb;
        const_in = dec_const;
        state_d  = FETCH;
        case (dec_op)
          OP_ALU: begin
            RW      = 1'b1;
            flags_d = {V, C, N, Z};
          end
          OP_LDI:       RW = 1'b1;
          OP_LD, OP_ST: state_d = MEM;
          // pc_q already points past the branch; 8-bit add of the
          // two's-complement offset gives the modulo-256 target.
          OP_BR: if (cond_taken(dec_cond, flags_q)) pc_d = pc_q + dec_imm8;
          OP_JMP:       pc_d = dec_imm8;
          OP_HALT:      state_d = HALT;
          default:      state_d = FETCH;
        endcase
      end
      MEM: begin
        DA       = dec_da;
        AA       = dec_aa;
        BA       = dec_ba;
        dmem_req = 1'b1;
        dmem_we  = (dec_op == OP_ST);
        if (dmem_done) begin
          if (dec_op == OP_LD) begin
            RW = 1'b1;
            MD = 1'b1;
          end
          state_d = FETCH;
        end
      end
      HALT: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench. The driver feeds
// instructions, runs an instruction-level model and queues the expected
// fetch addresses, register writes and memory accesses; a negedge monitor
// pops and compares whenever the DUT presents one of those events.
module tb_control_sequencer;

  localparam logic [3:0] EXP_FS_MOVB = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_valid = 1'b0;
  logic [7:0]  imem_addr, const_in, pc;
  logic [15:0] imem_data = 16'd0;
  logic        RW, MB, MD, dmem_req, dmem_we, halted;
  logic [2:0]  DA, AA, BA;
  logic [3:0]  FS;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic        dmem_done = 1'b0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .RW(RW), .DA(DA), .AA(AA), .BA(BA), .MB(MB), .FS(FS), .MD(MD), .const_in(const_in),
    .V(V), .C(C), .N(N), .Z(Z),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_done(dmem_done),
    .pc(pc), .halted(halted)
  );

  typedef struct {
    logic [2:0] da, aa, ba;
    logic [3:0] fs;
    logic       mb, md;
    logic [7:0] cst, pcv;
    bit         chk_aa, chk_ba, chk_fs, chk_mb, chk_const;
  } reg_ev_t;

  typedef struct {
    logic       we;
    logic [2:0] aa, ba;
    bit         chk_ba;
    int         cycles;
  } mem_ev_t;

  logic [7:0] fetch_q[$];
  reg_ev_t    reg_q[$];
  mem_ev_t    mem_q[$];

  int checks = 0;
  int failures = 0;

  // model state
  logic [7:0] m_pc = 8'h00;
  logic [3:0] m_flags = 4'h0;   // {V,C,N,Z} of last ALU instruction
  int         mem_wait = 0;
  int         n_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit br_taken(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[1];
      3'd4: return f[2];
      3'd5: return f[3];
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: what one instruction must cause.
  task automatic model_exec(input logic [15:0] ir, input logic [3:0] fl, input int wt);
    int         npc;
    reg_ev_t    r;
    mem_ev_t    m;
    logic [7:0] off;
    r = '{default: 0};
    m = '{default: 0};
    fetch_q.push_back(m_pc);
    npc   = int'(m_pc) + 1;
    r.pcv = npc[7:0];
    case (ir[15:14])
      2'b00: begin
        r.da = ir[9:7]; r.aa = ir[6:4]; r.ba = ir[3:1]; r.fs = ir[13:10];
        r.chk_aa = 1; r.chk_ba = 1; r.chk_fs = 1; r.chk_mb = 1;
        reg_q.push_back(r);
        m_flags = fl;
      end
      2'b01: begin
        case (ir[13:12])
          2'b00: begin
            r.da = ir[11:9]; r.cst = ir[7:0]; r.fs = EXP_FS_MOVB; r.mb = 1'b1;
            r.chk_fs = 1; r.chk_mb = 1; r.chk_const = 1;
            reg_q.push_back(r);
          end
          2'b01: begin
            m.we = 1'b0; m.aa = ir[8:6]; m.cycles = wt + 1;
            mem_q.push_back(m);
            r.da = ir[11:9]; r.aa = ir[8:6]; r.md = 1'b1; r.chk_aa = 1;
            reg_q.push_back(r);
          end
          2'b10: begin
            m.we = 1'b1; m.aa = ir[8:6]; m.ba = ir[5:3]; m.chk_ba = 1; m.cycles = wt + 1;
            mem_q.push_back(m);
          end
          default: ;
        endcase
      end
      2'b10: begin
        off = ir[7:0];
        if (br_taken(ir[13:11], m_flags)) npc = npc + int'($signed(off));
      end
      default: npc = int'(ir[7:0]);
    endcase
    m_pc = npc[7:0];
  endtask

  // One cycle of input driving, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dmem_req) begin
      if (mem_wait == 0) dmem_done = 1'b1;
      else begin
        dmem_done = 1'b0;
        mem_wait--;
      end
    end else begin
      dmem_done = ($urandom_range(3) == 0);   // must be ignored
    end
    if (imem_req) imem_valid = 1'b0;
    else begin
      imem_valid = ($urandom_range(1) == 0);  // must be ignored
      imem_data  = 16'($urandom);
    end
  endtask

  task automatic send(input logic [15:0] ir, input logic [3:0] fl, input int wt);
    int n;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (imem_req && $urandom_range(2) != 0) break;
    end
    if (!imem_req) begin
      chk("fetch_timeout", imem_req, 1'b1);
    end else begin
      imem_valid = 1'b1;
      imem_data  = ir;
      {V, C, N, Z} = fl;
      mem_wait = wt;
      $display("issue #%0d pc=%02h ir=%04h flags=%1h wait=%0d", n_issued, m_pc, ir, fl, wt);
      n_issued++;
      model_exec(ir, fl, wt);
    end
  endtask

  task automatic model_reset();
    fetch_q.delete();
    reg_q.delete();
    mem_q.delete();
    m_pc = 8'h00;
    m_flags = 4'h0;
    mem_wait = 0;
    imem_valid = 1'b0;
    dmem_done = 1'b0;
  endtask

  task automatic send_random();
    logic [15:0] ir;
    ir = 16'($urandom);
    if (ir[15:12] == 4'b0111) ir[13:12] = 2'b00;  // keep HALT out of random stream
    send(ir, 4'($urandom_range(15)), $urandom_range(3));
  endtask

  // Monitor / scoreboard
  int req_cycles = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cycles = 0;
    end else begin
      if (imem_req && imem_valid) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", 1, 0);
        else begin
          logic [7:0] e;
          e = fetch_q.pop_front();
          chk("fetch_addr", imem_addr, e);
          chk("fetch_pc", pc, e);
        end
      end
      if (RW) begin
        chk("rw_not_in_fetch", imem_req, 1'b0);
        if (reg_q.size() == 0) chk("rw_unexpected", 1, 0);
        else begin
          reg_ev_t r;
          r = reg_q.pop_front();
          $display("regwrite DA=%0d AA=%0d BA=%0d FS=%h MB=%0d MD=%0d K=%02h pc=%02h", DA, AA, BA, FS, MB, MD, const_in, pc);
          chk("rw_da", DA, r.da);
          chk("rw_md", MD, r.md);
          chk("rw_pc", pc, r.pcv);
          if (r.chk_aa) chk("rw_aa", AA, r.aa);
          if (r.chk_ba) chk("rw_ba", BA, r.ba);
          if (r.chk_fs) chk("rw_fs", FS, r.fs);
          if (r.chk_mb) chk("rw_mb", MB, r.mb);
          if (r.chk_const) chk("rw_const", const_in, r.cst);
        end
      end
      if (dmem_req) begin
        req_cycles++;
        if (dmem_done) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            mem_ev_t m;
            m = mem_q.pop_front();
            $display("memaccess we=%0d AA=%0d BA=%0d req_cycles=%0d", dmem_we, AA, BA, req_cycles);
            chk("mem_we", dmem_we, m.we);
            chk("mem_aa", AA, m.aa);
            chk("mem_req_cycles", req_cycles, m.cycles);
            if (m.chk_ba) chk("mem_ba", BA, m.ba);
          end
          req_cycles = 0;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int fetch_cnt;
    // Power-on reset, held 3 cycles
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_pc", pc, 8'h00);
    chk("reset_imem_addr", imem_addr, 8'h00);
    chk("reset_ctrl", {RW, DA, AA, BA, MB, FS, MD, const_in}, 0);
    chk("reset_dmem_halt", {dmem_req, dmem_we, halted}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed program
    send(16'h4A5C, 4'h0, 0);   // LDI R5, 0x5C @00
    send(16'hC00F, 4'h0, 0);   // JMP 0x0F
    send(16'h14A6, 4'h1, 0);   // ALU FS=5 DA1 AA2 BA3 with Z=1 @0F
    send(16'h88FE, 4'h0, 0);   // BR Z -2 @10, live Z=0, latched Z=1
    send(16'h5980, 4'hF, 3);   // LD R4,[R6] with 3 wait states @0F
    send(16'h6050, 4'h0, 0);   // ST [R1],R2 immediate done
    send(16'hC0FF, 4'h0, 0);   // JMP 0xFF
    send(16'h0000, 4'h0, 0);   // ALU @FF, next fetch at 00
    send(16'hC080, 4'h0, 0);   // JMP 0x80
    send(16'h0000, 4'h0, 0);   // fetch at 80

    for (int i = 0; i < 250; i++) send_random();

    // HALT: must stop fetching until reset
    send(16'h7000, 4'h0, 0);
    n = 0;
    while (n < 10 && !halted) begin tick(); n++; end
    chk("halt_reached", halted, 1'b1);
    fetch_cnt = 0;
    repeat (20) begin
      tick();
      if (imem_req) fetch_cnt++;
    end
    chk("halt_no_fetch", fetch_cnt, 0);
    chk("halt_held", halted, 1'b1);

    // Reset out of HALT, then reset in the middle of a long load
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("halt_cleared", halted, 1'b0);
    send(16'h0000, 4'h0, 0);
    send(16'h5980, 4'h0, 20);
    n = 0;
    while (n < 10 && !dmem_req) begin tick(); n++; end
    chk("mid_mem_req_seen", dmem_req, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_mem_req_dropped", dmem_req, 1'b0);
    chk("mid_mem_rw_low", RW, 1'b0);
    chk("mid_mem_pc", pc, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(16'h4A5C, 4'h0, 0);
    for (int i = 0; i < 30; i++) send_random();

    repeat (30) tick();
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("reg_q_drained", reg_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit directly upstream of the 8-bit datapath.
- Fetches 16-bit instructions, holds PC and IR, and drives the datapath control word (RW, DA, AA, BA, MB, FS, MD, const_in).
- Consumes the datapath's V/C/N/Z flags for conditional branches.
- Sequences data-memory handshakes for load and store.

Parameters:
- FS_MOVB, 4'b1100, function-unit code that passes operand B to the output; used by LDI.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request, high while in FETCH
- imem_addr  out  8  fetch address, equals PC
- imem_data  in  16  instruction word
- imem_valid  in  1  imem_data valid, sampled in FETCH
- RW  out  1  register-file write enable
- DA  out  3  destination register
- AA  out  3  A-operand register (also the memory address source)
- BA  out  3  B-operand register
- MB  out  1  1 selects const_in as operand B
- FS  out  4  function select
- MD  out  1  1 selects data_in as write-back data
- const_in  out  8  immediate value
- V, C, N, Z  in  1 each  datapath flags
- dmem_req  out  1  data-memory request, level signal
- dmem_we  out  1  1 = store, 0 = load
- dmem_done  in  1  data-memory access complete
- pc  out  8  current PC
- halted  out  1  high in HALT

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: PC = RESET_PC, IR = 0, flag register = 0, state = FETCH. All control outputs, dmem_req, dmem_we and halted are 0.
- Instruction formats (IR[15:14] = class):
  - Class 00, ALU: FS = IR[13:10], DA = IR[9:7], AA = IR[6:4], BA = IR[3:1]. IR[0] is ignored.
  - Class 01, IR[13:12] = sub-op:
    - 00 LDI: DA = IR[11:9], const_in = IR[7:0].
    - 01 LD: DA = IR[11:9], AA = IR[8:6].
    - 10 ST: AA = IR[8:6] holds the address, BA = IR[5:3] holds the data.
    - 11 HALT.
  - Class 10, BR: cond = IR[13:11], offset = IR[7:0] as signed 8-bit. Cond codes: 000 always, 001 Z, 010 !Z, 011 N, 100 C, 101 V. Codes 110 and 111 are never taken.
  - Class 11, JMP: target = IR[7:0].
- State FETCH:
  - imem_req = 1 (combinational from state).
  - On imem_valid: latch IR, set PC = PC+1 (wraps 8'hFF to 8'h00), go to EXEC.
  - Otherwise stay in FETCH.
- State EXEC: decode IR combinationally, then:
  - ALU: RW = 1, MB = 0, MD = 0 for this one cycle. Latch {V,C,N,Z} into the flag register at the end of the cycle. Go to FETCH.
  - LDI: RW = 1, MB = 1, MD = 0, FS = FS_MOVB. Flags are not updated. Go to FETCH.
  - LD / ST: set dmem_we (1 for ST, 0 for LD), go to MEM.
  - BR: if taken, PC = PC + offset, modulo 256. PC has already been incremented, so the target is the instruction address + 1 + offset. Go to FETCH.
  - JMP: PC = target. Go to FETCH.
  - HALT: go to HALT.
- State MEM:
  - dmem_req = 1; AA, BA and DA are held stable.
  - On dmem_done for LD: RW = 1 and MD = 1 in that same cycle only.
  - On dmem_done (LD or ST): go to FETCH, dmem_req drops next cycle.
  - Otherwise stay in MEM indefinitely.
- State HALT: halted = 1, all enables are 0. The block leaves HALT only on reset.
- RW timing: RW is high for exactly one cycle per register write, never in FETCH. DA, AA, BA, FS, MB and const_in are valid throughout any cycle in which RW = 1.
- Latency with zero-wait memories: ALU/LDI/BR/JMP take 2 cycles; LD/ST take 3 cycles.
- Branch flags come from the last completed ALU-class instruction, not from the live V/C/N/Z.
- Reset mid-operation: reset asserted in MEM abandons the access; dmem_req and RW drop asynchronously.
- imem_valid and dmem_done are ignored outside FETCH and MEM respectively.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (FETCH, EXEC, MEM, HALT),
  - class codes and sub-op codes,
  - cond codes,
  - the default FS_MOVB.
- One combinational sub-module, instr_decode: maps IR to the control-word fields, an op-kind tag, cond and imm8. The sequencer holds only state, PC, IR and flags.

Test Plan:
- Reset then LDI: rst_n low for 3 cycles, then imem_data = 16'h4A5C at PC 0 with imem_valid = 1 → PC = 8'h00, all outputs 0 after reset. In EXEC cycle: RW = 1, DA = 5, MB = 1, const_in = 8'h5C, FS = FS_MOVB. pc = 8'h01.
- ALU with flags: instruction with class 00, FS = 4'b0101, DA = 1, AA = 2, BA = 3, datapath Z = 1 → one RW pulse with DA = 1, AA = 2, BA = 3. Then BR cond 001 with offset 8'hFE at address 8'h10 → pc = 8'h0F.
- Load with wait states: LD with DA = 4, AA = 6, dmem_done held low 3 cycles → dmem_req high 4 cycles, dmem_we = 0. RW = 1 and MD = 1 only in the dmem_done cycle, DA = 4.
- Store: ST with AA = 1, BA = 2, dmem_done immediate → dmem_req and dmem_we high for 1 cycle, RW never asserted, next fetch at PC+1.
- PC wrap and JMP: NOP-class ALU at 8'hFF → next imem_addr = 8'h00. JMP 8'h80 → next imem_addr = 8'h80.
- Reset mid-MEM and HALT:
  - rst_n low during MEM → dmem_req drops before the next clock edge, pc = 8'h00.
  - HALT instruction → halted = 1, no further imem_req until reset.
